mux2_rr_arbiter: RTL

Round-robin arbiter that shares one 2-to-1 mux datapath between two burst requesters, A and B. It grants one requester at a time, holds the grant for a whole burst (until `last`), and drives the mux select. It can pre-empt a requester that holds the mux too long while the other is waiting. It sits in front of any shared output that the existing 2-to-1 mux feeds.

---
 rtl/mux2_rr_arbiter_pkg.sv | 13 +
 rtl/mux2_rr_arbiter_mux_2to1.sv | 11 +
 rtl/mux2_rr_arbiter.sv | 113 +++++++++++
 3 files changed

// File: rtl/mux2_rr_arbiter_pkg.sv
// Shared encodings for the two-requester round-robin mux arbiter.
package mux2_rr_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_A = 2'd1,
        GNT_B = 2'd2
    } state_t;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/mux2_rr_arbiter_mux_2to1.sv
// Existing single-bit 2-to-1 mux: y follows a when sel = 0, b when sel = 1.
module mux_2to1 (
    output logic y,
    input  logic a,
    input  logic b,
    input  logic sel
);

    assign y = sel ? b : a;

endmodule

// File: rtl/mux2_rr_arbiter.sv
// Round-robin burst arbiter for two requesters sharing one 2-to-1 mux datapath,
// with optional beat-count pre-emption when the other side is waiting.
module mux2_rr_arbiter
    import mux2_rr_arbiter_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_a,
    input  logic             last_a,
    input  logic [WIDTH-1:0] a,
    input  logic             req_b,
    input  logic             last_b,
    input  logic [WIDTH-1:0] b,
    output logic             gnt_a,
    output logic             gnt_b,
    output logic             sel,
    output logic [WIDTH-1:0] y,
    output logic             valid
);

    localparam int CW = $clog2(MAX_HOLD + 2);

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] hold_cnt;
    logic [CW-1:0] hold_nxt;
    logic          prio;
    logic          prio_nxt;
    logic          own_req;
    logic          own_last;
    logic          oth_req;
    logic          cap_hit;
    logic          rel;

    always_comb begin
        own_req  = (state == GNT_B) ? req_b  : req_a;
        own_last = (state == GNT_B) ? last_b : last_a;
        oth_req  = (state == GNT_B) ? req_a  : req_b;
        cap_hit  = 1'b0;
        // hold_cnt saturates at MAX_HOLD, so >= still fires if the other side shows up late
        if (MAX_HOLD != 0)
            cap_hit = own_req && oth_req && (int'(hold_cnt) + 1 >= MAX_HOLD);
        rel = (own_req && own_last) || !own_req || cap_hit;
    end

    always_comb begin
        state_nxt = state;
        hold_nxt  = hold_cnt;
        prio_nxt  = prio;
        case (state)
            IDLE: begin
                hold_nxt = '0;
                if (req_a && req_b)
                    state_nxt = (prio == SEL_B) ? GNT_B : GNT_A;
                else if (req_a)
                    state_nxt = GNT_A;
                else if (req_b)
                    state_nxt = GNT_B;
            end
            GNT_A, GNT_B: begin
                if (rel) begin
                    hold_nxt = '0;
                    prio_nxt = (state == GNT_A) ? SEL_B : SEL_A;
                    if (oth_req)
                        state_nxt = (state == GNT_A) ? GNT_B : GNT_A;
                    else if (own_req)
                        state_nxt = state;
                    else
                        state_nxt = IDLE;
                end else if (hold_cnt != CW'(MAX_HOLD)) begin
                    hold_nxt = hold_cnt + CW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            gnt_a    <= 1'b0;
            gnt_b    <= 1'b0;
            sel      <= SEL_A;
            hold_cnt <= '0;
            prio     <= SEL_A;
        end else begin
            state    <= state_nxt;
            gnt_a    <= (state_nxt == GNT_A);
            gnt_b    <= (state_nxt == GNT_B);
            hold_cnt <= hold_nxt;
            prio     <= prio_nxt;
            if (state_nxt == GNT_A)
                sel <= SEL_A;
            else if (state_nxt == GNT_B)
                sel <= SEL_B;
        end
    end

    assign valid = (gnt_a && req_a) || (gnt_b && req_b);

    for (genvar i = 0; i < WIDTH; i++) begin : g_mux
        mux_2to1 u_mux (
            .y   (y[i]),
            .a   (a[i]),
            .b   (b[i]),
            .sel (sel)
        );
    end

endmodule
